// File: rtl/data_memory_resp.sv
// Data-memory responder: word RAM behind a req/ack handshake with fixed LATENCY.
// Optional byte-enable store support is compiled in with `define DMEM_BYTE_WRITE_EN.
module data_memory_resp #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [3:0]  be_i,
`endif
  output logic        ack_o,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request is taken on any rising edge where req_i=1 and the block is
  // IDLE (busy_o=0). It completes with a single-cycle ack_o LATENCY cycles later; the
  // requester must not expect another acceptance until busy_o has returned to 0.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_data;
  logic                r_err;
  logic [31:0]         r_mem [DEPTH];

  logic                w_accept;
  logic                w_access;
  logic                w_sel_we;
  logic [ADDR_W+1:0]   w_sel_addr;
  logic [31:0]         w_sel_wdata;
  logic [3:0]          w_sel_be;
  logic [ADDR_W-1:0]   w_index;
  logic                w_misaligned;
  logic                w_unused_addr;

  assign w_unused_addr = ^addr_i[31:ADDR_W+2];

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_i) w_next = (LATENCY > 1) ? S_WAIT : S_ACK;
      S_WAIT:  if (r_cnt == 4'd1) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ack_o       = (r_state == S_ACK);
    busy_o      = (r_state != S_IDLE);
    err_o       = r_err;
    data_o      = r_data;
    dbg_state_o = r_state;
  end

  assign w_accept = (r_state == S_IDLE) && req_i;
  // The RAM access happens on the edge that enters ACK. With LATENCY=1 that is the
  // acceptance edge itself, so the live inputs stand in for the latched request.
  assign w_access = (r_state != S_ACK) && (w_next == S_ACK);

  always_comb begin
    if (r_state == S_IDLE) begin
      w_sel_we    = we_i;
      w_sel_addr  = addr_i[ADDR_W+1:0];
      w_sel_wdata = data_i;
    end else begin
      w_sel_we    = r_we;
      w_sel_addr  = r_addr;
      w_sel_wdata = r_wdata;
    end
  end

`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0] r_be;

  always_ff @(posedge clk_i) begin
    if (!rst_i)        r_be <= 4'h0;
    else if (w_accept) r_be <= be_i;
  end

  assign w_sel_be = (r_state == S_IDLE) ? be_i : r_be;
`else
  assign w_sel_be = 4'hF;
`endif

  assign w_index      = w_sel_addr[ADDR_W+1:2];
  assign w_misaligned = |w_sel_addr[1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_data  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= we_i;
        r_addr  <= addr_i[ADDR_W+1:0];
        r_wdata <= data_i;
        r_cnt   <= CNT_INIT;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_err <= w_misaligned;
        if (!w_misaligned && !w_sel_we) r_data <= r_mem[w_index];
      end else if (r_state == S_ACK) begin
        r_err <= 1'b0;
      end
    end
  end

  // RAM contents survive reset; reset only suppresses an in-flight store.
  always_ff @(posedge clk_i) begin
    if (rst_i && w_access && w_sel_we && !w_misaligned) begin
      for (int b = 0; b < 4; b++) begin
        if (w_sel_be[b]) r_mem[w_index][8*b +: 8] <= w_sel_wdata[8*b +: 8];
      end
    end
  end

endmodule
